ahb_res_reader: RTL and testbench
=================================

# ahb_res_reader

AHB-Lite slave read port that drains the convolver's result FIFO onto the bus. It sits between the result FIFO (pop side: renable/empty/data) and the AHB-Lite interconnect. It exposes a pop-on-read RESULT register, a STATUS register and a CTRL register. It inserts wait states while the FIFO is empty and returns an ERROR response if no result arrives within a bounded number of cycles.

## Interface
- MAX_WAIT, 16: maximum consecutive wait cycles on an empty-FIFO RESULT read before ERROR (≥1, ≤255)
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  reset n_rst, asynchronous, active-low
- hsel  in  1  slave select
- haddr  in  4  low address bits; word offsets 0x0 RESULT, 0x4 STATUS, 0x8 CTRL
- htrans  in  2  AHB transfer type; transfer valid when htrans[1]=1 (NONSEQ/SEQ)
- hwrite  in  1  1 = write
- hwdata  in  32  write data (data phase)
- hready  in  1  bus-wide ready; address phase sampled only when hready=1
- hrdata  out  32  read data, valid when hreadyout=1 in a read data phase
- hreadyout  out  1  slave ready
- hresp  out  1  0 OKAY, 1 ERROR
- fifo_empty  in  1  result FIFO empty flag
- fifo_data  in  16  FIFO head word, valid in the same cycle as fifo_renable=1
- fifo_renable  out  1  pop strobe to result FIFO

## Operation
- Address phase accepted when hsel & htrans[1] & hready. Registered at the clock edge: addr, write flag. The data phase is the following cycle(s).
- States: IDLE, RD_RES, ERR1, ERR2. IDLE covers no-transfer cycles and all zero-wait data phases.
- RESULT read (0x0, hwrite=0) → RD_RES.
  - Cycle with fifo_empty=0: fifo_renable=1, hrdata={16'h0, fifo_data}, hreadyout=1, pop_cnt increments.
  - Cycle with fifo_empty=1: fifo_renable=0, hreadyout=0, hrdata=0, wait_cnt increments.
  - After MAX_WAIT consecutive empty cycles, next state is ERR1. No pop occurs in ERR1 even if the FIFO fills.
- ERR1: hreadyout=0, hresp=1. ERR2: hreadyout=1, hresp=1. Then IDLE, or a new data phase if an address phase is accepted in ERR2.
- STATUS read (0x4): one cycle, hrdata={pop_cnt[15:0], 15'h0, fifo_empty}, where fifo_empty is sampled in the data-phase cycle. OKAY.
- CTRL write (0x8): one cycle. hwdata[0]=1 clears pop_cnt. OKAY.
- Write to RESULT (0x0): two-cycle ERROR, via ERR1/ERR2, with no pop.
- Any other read or write (unmapped, reads of CTRL, writes to STATUS): hrdata=0, OKAY, no side effect.
- pop_cnt: 16-bit, wraps 0xFFFF→0x0000. A clear and a pop in the same cycle leaves the result 0 (clear wins).
- wait_cnt: 8-bit. Cleared on entry to RD_RES and on every accepted address phase.
- fifo_renable is asserted only in RD_RES with fifo_empty=0, and never more than once per transfer.

## Timing
- Reset values: hrdata=0, hreadyout=1, hresp=0, fifo_renable=0. State IDLE, pop_cnt=0, wait_cnt=0.
- Outputs hrdata, hreadyout, hresp and fifo_renable are combinational from state and the data-phase inputs.
- RESULT read with data present: 0 wait states. Data is returned in the first data-phase cycle.
- RESULT read with empty FIFO: N wait cycles, where N is the number of cycles until fifo_empty=0, capped at MAX_WAIT. Otherwise MAX_WAIT wait cycles are followed by ERR1 and ERR2.
- Pipelining: a new address phase may be accepted in any cycle with hreadyout=1 (POP cycle, IDLE data phase, ERR2). Back-to-back RESULT reads pop one word per cycle.
- hrdata=0 whenever hreadyout=0 or the cycle is not a read data phase.
- Asynchronous reset mid-transfer forces IDLE immediately: pending transfer dropped, no pop, outputs at reset values.

## Test plan
- Reset then STATUS read → hrdata=0x0000_0001 (empty=1, pop_cnt=0), hreadyout=1, hresp=0.
- FIFO holds 0x1234 and 0xBEEF; two back-to-back RESULT reads → hrdata 0x0000_1234 then 0x0000_BEEF on consecutive cycles. fifo_renable high exactly 2 cycles. STATUS then reads 0x0002_0001.
- Empty FIFO, RESULT read, FIFO goes non-empty (data 0x00AA) after 3 cycles → 3 cycles hreadyout=0, then one cycle with hreadyout=1, hrdata=0x0000_00AA and a single pop.
- MAX_WAIT=4, FIFO empty throughout, RESULT read → 4 wait cycles, ERR1 (hreadyout=0, hresp=1), ERR2 (hreadyout=1, hresp=1), no fifo_renable.
- After 3 pops, CTRL write hwdata=1 → STATUS reads pop_cnt=0. Write to 0x0 → ERROR pair, FIFO untouched. Read of 0xC → 0, OKAY.
- n_rst pulsed low during a RESULT wait state → outputs return to reset values asynchronously. After release, STATUS shows pop_cnt=0.

Source files
------------

// File: rtl/ahb_res_reader.sv
// AHB-Lite slave that drains the convolver result FIFO through a pop-on-read RESULT register,
// with STATUS/CTRL registers, empty-FIFO wait states and a bounded-wait ERROR response.
module ahb_res_reader #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        hsel,
    input  logic [3:0]  haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp,
    input  logic        fifo_empty,
    input  logic [15:0] fifo_data,
    output logic        fifo_renable
);
    localparam logic [3:0] ADDR_RESULT = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;
    localparam logic [7:0] WAIT_LAST   = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_RES = 2'd1,
        ERR1   = 2'd2,
        ERR2   = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        dp_act;
    logic        dp_write;
    logic [3:0]  dp_addr;
    logic [15:0] pop_cnt, pop_cnt_nxt;
    logic [7:0]  wait_cnt, wait_cnt_nxt;
    logic        accept;
    logic        pop;
    logic        clr;

    logic unused_bits;
    assign unused_bits = ^{hwdata[31:1], htrans[0]};

    // A stalled data phase never takes a new address phase, even if hready is driven high.
    assign accept = hsel & htrans[1] & hready & hreadyout;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            dp_act   <= 1'b0;
            pop_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            dp_act   <= accept;
            pop_cnt  <= pop_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Address-phase capture; only meaningful while dp_act qualifies it.
    always_ff @(posedge clk) begin
        if (accept) begin
            dp_addr  <= haddr;
            dp_write <= hwrite;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        hrdata       = '0;
        hreadyout    = 1'b1;
        hresp        = 1'b0;
        fifo_renable = 1'b0;
        pop          = 1'b0;
        clr          = 1'b0;

        case (state)
            IDLE: begin
                if (dp_act && !dp_write && dp_addr == ADDR_STATUS)
                    hrdata = {pop_cnt, 15'h0, fifo_empty};
                if (dp_act && dp_write && dp_addr == ADDR_CTRL && hwdata[0])
                    clr = 1'b1;
            end
            RD_RES: begin
                if (!fifo_empty) begin
                    fifo_renable = 1'b1;
                    pop          = 1'b1;
                    hrdata       = {16'h0, fifo_data};
                    state_nxt    = IDLE;
                end else begin
                    hreadyout    = 1'b0;
                    wait_cnt_nxt = wait_cnt + 8'd1;
                    if (wait_cnt == WAIT_LAST)
                        state_nxt = ERR1;
                end
            end
            ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_nxt = ERR2;
            end
            ERR2: begin
                hresp     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (accept) begin
            wait_cnt_nxt = '0;
            if (haddr == ADDR_RESULT)
                state_nxt = hwrite ? ERR1 : RD_RES;
            else
                state_nxt = IDLE;
        end

        if (clr)
            pop_cnt_nxt = '0;
        else if (pop)
            pop_cnt_nxt = pop_cnt + 16'd1;
        else
            pop_cnt_nxt = pop_cnt;
    end
endmodule

// File: tb/tb_ahb_res_reader.sv
// Directed bench for ahb_res_reader: a small FIFO model feeds the DUT and every
// data-phase output is compared against hand-computed values.
module tb_ahb_res_reader;
    logic        clk = 1'b0;
    logic        n_rst;
    logic        hsel;
    logic [3:0]  haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic        fifo_empty;
    logic [15:0] fifo_data;
    logic        fifo_renable;

    ahb_res_reader #(.MAX_WAIT(4)) dut (
        .clk(clk), .n_rst(n_rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hwdata(hwdata), .hready(hready), .hrdata(hrdata),
        .hreadyout(hreadyout), .hresp(hresp), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_renable(fifo_renable)
    );

    always #5 clk = ~clk;

    // Single-slave system: the bus ready is this slave's ready.
    assign hready = hreadyout;

    logic [15:0] fq [8];
    logic [3:0]  fwr = '0;
    logic [3:0]  frd = '0;
    int          pop_seen = 0;
    int          p0;

    assign fifo_empty = (fwr == frd);
    assign fifo_data  = fq[frd[2:0]];

    always @(posedge clk) begin
        if (fifo_renable) begin
            frd      <= frd + 4'd1;
            pop_seen <= pop_seen + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] v);
        fq[fwr[2:0]] = v;
        fwr = fwr + 4'd1;
    endtask

    task automatic issue(input logic [3:0] a, input logic w);
        @(negedge clk);
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = a;
        hwrite = w;
    endtask

    task automatic idle_bus();
        @(negedge clk);
        hsel   = 1'b0;
        htrans = 2'b00;
        haddr  = 4'h0;
        hwrite = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; hsel = 1'b0; haddr = '0; htrans = '0; hwrite = 1'b0; hwdata = '0;
        repeat (2) @(negedge clk);
        check("rst_hrdata", hrdata, 32'h0);
        check("rst_hreadyout", 32'(hreadyout), 32'd1);
        check("rst_hresp", 32'(hresp), 32'd0);
        check("rst_renable", 32'(fifo_renable), 32'd0);
        n_rst = 1'b1;

        // STATUS after reset: pop_cnt=0, empty=1
        issue(4'h4, 1'b0);
        idle_bus();
        check("status0", hrdata, 32'h0000_0001);
        check("status0_rdy", 32'(hreadyout), 32'd1);
        check("status0_resp", 32'(hresp), 32'd0);

        // Back-to-back RESULT reads
        push(16'h1234);
        push(16'hBEEF);
        p0 = pop_seen;
        issue(4'h0, 1'b0);
        issue(4'h0, 1'b0);
        check("b2b_data0", hrdata, 32'h0000_1234);
        check("b2b_rdy0", 32'(hreadyout), 32'd1);
        check("b2b_ren0", 32'(fifo_renable), 32'd1);
        idle_bus();
        check("b2b_data1", hrdata, 32'h0000_BEEF);
        check("b2b_rdy1", 32'(hreadyout), 32'd1);
        check("b2b_ren1", 32'(fifo_renable), 32'd1);
        issue(4'h4, 1'b0);
        check("b2b_ren_after", 32'(fifo_renable), 32'd0);
        idle_bus();
        check("b2b_status", hrdata, 32'h0002_0001);
        check("b2b_pops", 32'(pop_seen - p0), 32'd2);

        // Empty FIFO, data arrives after 3 wait cycles
        p0 = pop_seen;
        issue(4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) idle_bus(); else @(negedge clk);
            check("wait_rdy", 32'(hreadyout), 32'd0);
            check("wait_data", hrdata, 32'h0);
            check("wait_ren", 32'(fifo_renable), 32'd0);
        end
        @(negedge clk);
        push(16'h00AA);
        #1;
        check("late_rdy", 32'(hreadyout), 32'd1);
        check("late_data", hrdata, 32'h0000_00AA);
        check("late_ren", 32'(fifo_renable), 32'd1);
        @(negedge clk);
        check("late_after_ren", 32'(fifo_renable), 32'd0);
        check("late_pops", 32'(pop_seen - p0), 32'd1);

        // Timeout: 4 waits, ERR1, ERR2; data arriving in ERR1 is not popped
        p0 = pop_seen;
        issue(4'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) idle_bus(); else @(negedge clk);
            check("to_wait_rdy", 32'(hreadyout), 32'd0);
            check("to_wait_resp", 32'(hresp), 32'd0);
        end
        @(negedge clk);
        push(16'h5555);
        #1;
        check("err1_rdy", 32'(hreadyout), 32'd0);
        check("err1_resp", 32'(hresp), 32'd1);
        check("err1_ren", 32'(fifo_renable), 32'd0);
        @(negedge clk);
        check("err2_rdy", 32'(hreadyout), 32'd1);
        check("err2_resp", 32'(hresp), 32'd1);
        check("err2_ren", 32'(fifo_renable), 32'd0);
        @(negedge clk);
        check("to_idle_resp", 32'(hresp), 32'd0);
        check("to_pops", 32'(pop_seen - p0), 32'd0);

        // pop_cnt is 3 and FIFO holds one word; then clear via CTRL
        issue(4'h4, 1'b0);
        idle_bus();
        check("status3", hrdata, 32'h0003_0000);
        issue(4'h8, 1'b1);
        idle_bus();
        hwdata = 32'h0000_0001;
        check("ctrl_rdy", 32'(hreadyout), 32'd1);
        check("ctrl_resp", 32'(hresp), 32'd0);
        issue(4'h4, 1'b0);
        hwdata = 32'h0;
        idle_bus();
        check("status_clr", hrdata, 32'h0000_0000);

        // Write to RESULT: ERROR pair, no pop
        p0 = pop_seen;
        issue(4'h0, 1'b1);
        idle_bus();
        check("wres_err1_rdy", 32'(hreadyout), 32'd0);
        check("wres_err1_resp", 32'(hresp), 32'd1);
        check("wres_ren", 32'(fifo_renable), 32'd0);
        @(negedge clk);
        check("wres_err2_rdy", 32'(hreadyout), 32'd1);
        check("wres_err2_resp", 32'(hresp), 32'd1);
        check("wres_pops", 32'(pop_seen - p0), 32'd0);

        // Unmapped read
        issue(4'hC, 1'b0);
        idle_bus();
        check("unmap_data", hrdata, 32'h0);
        check("unmap_resp", 32'(hresp), 32'd0);
        check("unmap_rdy", 32'(hreadyout), 32'd1);

        // Drain the held word, then reset during a wait state
        issue(4'h0, 1'b0);
        idle_bus();
        check("drain_data", hrdata, 32'h0000_5555);
        issue(4'h0, 1'b0);
        idle_bus();
        check("rstw_rdy", 32'(hreadyout), 32'd0);
        #2 n_rst = 1'b0;
        #1;
        check("arst_hrdata", hrdata, 32'h0);
        check("arst_rdy", 32'(hreadyout), 32'd1);
        check("arst_resp", 32'(hresp), 32'd0);
        check("arst_ren", 32'(fifo_renable), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        issue(4'h4, 1'b0);
        idle_bus();
        check("arst_status", hrdata, 32'h0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
